// File: rtl/sync_fifo_asym.sv
// Single-clock FIFO with independent write/read widths (power-of-2 ratio).
// Storage and pointers are kept in narrow units; flags and counts derive from pointer difference.
module sync_fifo_asym #(
    parameter int WR_WIDTH          = 8,
    parameter int RD_WIDTH          = 32,
    parameter int ADDR_WIDTH        = 4,
    parameter bit FWFT_EN           = 1'b1,
    parameter int PROG_FULL_THRESH  = 12,
    parameter int PROG_EMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WR_WIDTH-1:0]   din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  prog_full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic [RD_WIDTH-1:0]   dout,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  prog_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   rd_count
);

    localparam int NARROW   = (WR_WIDTH < RD_WIDTH) ? WR_WIDTH : RD_WIDTH;
    localparam int WR_UNITS = WR_WIDTH / NARROW;
    localparam int RD_UNITS = RD_WIDTH / NARROW;
    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int WR_SHIFT = $clog2(WR_UNITS);
    localparam int RD_SHIFT = $clog2(RD_UNITS);

    localparam logic [ADDR_WIDTH:0] DEPTH_U = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] WR_STEP = (ADDR_WIDTH+1)'(WR_UNITS);
    localparam logic [ADDR_WIDTH:0] RD_STEP = (ADDR_WIDTH+1)'(RD_UNITS);
    localparam logic [ADDR_WIDTH:0] PF_TH   = (ADDR_WIDTH+1)'(PROG_FULL_THRESH);
    localparam logic [ADDR_WIDTH:0] PE_TH   = (ADDR_WIDTH+1)'(PROG_EMPTY_THRESH);

    logic [NARROW-1:0]     r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [RD_WIDTH-1:0]   r_dout;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_fill;
    logic [ADDR_WIDTH:0]   w_free;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic                  w_full_raw;
    logic                  w_empty_raw;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [RD_WIDTH-1:0]   w_rd_word;

    // Pointer difference wraps naturally, so fill stays correct across MSB toggles.
    assign w_fill      = r_wptr - r_rptr;
    assign w_free      = DEPTH_U - w_fill;
    assign w_waddr     = r_wptr[ADDR_WIDTH-1:0];
    assign w_raddr     = r_rptr[ADDR_WIDTH-1:0];
    assign w_full_raw  = w_free < WR_STEP;
    assign w_empty_raw = w_fill < RD_STEP;

    assign wr_count    = w_fill >> WR_SHIFT;
    assign rd_count    = w_fill >> RD_SHIFT;

    // Flags read as full/empty for the whole time reset is held.
    assign full        = rst | w_full_raw;
    assign empty       = rst | w_empty_raw;
    assign prog_full   = rst | (wr_count >= PF_TH);
    assign prog_empty  = rst | (rd_count <= PE_TH);

    assign w_wr_acc    = wr_en & ~full;
    assign w_rd_acc    = rd_en & ~empty;

    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    // NOTE: the storage array has no reset; emptiness is defined by the pointers alone,
    // which keeps the array mappable onto RAM primitives.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            for (int k = 0; k < WR_UNITS; k++) begin
                r_mem[w_waddr + ADDR_WIDTH'(k)] <= din[k*NARROW +: NARROW];
            end
        end
    end

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_rd_word = '0;
        for (int k = 0; k < RD_UNITS; k++) begin
            w_rd_word[k*NARROW +: NARROW] = r_mem[w_raddr + ADDR_WIDTH'(k)];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_dout      <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + WR_STEP;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + RD_STEP;
                r_dout <= w_rd_word;
            end
            r_overflow  <= wr_en & full;
            r_underflow <= rd_en & empty;
        end
    end

    // In fall-through mode the head word is shown live; r_dout keeps the last popped word.
    assign dout = (FWFT_EN && !empty) ? w_rd_word : r_dout;

endmodule

// File: tb/tb_sync_fifo_asym.sv
// Bench for sync_fifo_asym: an 8->32 fall-through instance and a 32->8 standard-mode instance,
// each checked against a queue-based reference model and a scoreboard monitor.
`timescale 1ns/1ps
module tb_sync_fifo_asym;

    localparam int A_PF = 12;
    localparam int A_PE = 1;
    localparam int B_PF = 3;
    localparam int B_PE = 2;
    localparam int CAP  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;

    logic [7:0]  a_din;
    logic        a_wr_en, a_rd_en;
    logic        a_full, a_prog_full, a_overflow, a_empty, a_prog_empty, a_underflow;
    logic [4:0]  a_wr_count, a_rd_count;
    logic [31:0] a_dout;

    logic [31:0] b_din;
    logic        b_wr_en, b_rd_en;
    logic        b_full, b_prog_full, b_overflow, b_empty, b_prog_empty, b_underflow;
    logic [4:0]  b_wr_count, b_rd_count;
    logic [7:0]  b_dout;

    sync_fifo_asym #(
        .WR_WIDTH(8), .RD_WIDTH(32), .ADDR_WIDTH(4), .FWFT_EN(1'b1),
        .PROG_FULL_THRESH(A_PF), .PROG_EMPTY_THRESH(A_PE)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .din(a_din), .wr_en(a_wr_en), .full(a_full),
        .prog_full(a_prog_full), .overflow(a_overflow), .wr_count(a_wr_count),
        .dout(a_dout), .rd_en(a_rd_en), .empty(a_empty), .prog_empty(a_prog_empty),
        .underflow(a_underflow), .rd_count(a_rd_count)
    );

    sync_fifo_asym #(
        .WR_WIDTH(32), .RD_WIDTH(8), .ADDR_WIDTH(4), .FWFT_EN(1'b0),
        .PROG_FULL_THRESH(B_PF), .PROG_EMPTY_THRESH(B_PE)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .din(b_din), .wr_en(b_wr_en), .full(b_full),
        .prog_full(b_prog_full), .overflow(b_overflow), .wr_count(b_wr_count),
        .dout(b_dout), .rd_en(b_rd_en), .empty(b_empty), .prog_empty(b_prog_empty),
        .underflow(b_underflow), .rd_count(b_rd_count)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state: fill in narrow (byte) units plus expected-output queues.
    int          a_fill, b_fill;
    bit          a_ovf_exp, a_udf_exp, b_ovf_exp, b_udf_exp;
    bit          a_rd_acc, b_rd_acc;
    logic [31:0] a_exp_q[$];
    logic [7:0]  b_exp_q[$];
    logic [31:0] a_acc;
    int          a_nb;
    logic [31:0] a_last;
    logic [7:0]  b_last;
    int          b_wr_words;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: scoreboard had no expected entry at %0t", name, $time);
    endtask

    task automatic check_flags(input string tag, input int fill, input int wu, input int ru,
                               input int pft, input int pet, input bit e_ovf, input bit e_udf,
                               input logic full, input logic pfull, input logic ovf,
                               input logic [4:0] wc, input logic empty, input logic pempty,
                               input logic udf, input logic [4:0] rc);
        int ewc, erc;
        ewc = fill / wu;
        erc = fill / ru;
        check({tag, "_full"},       32'(full),   32'((CAP - fill) < wu));
        check({tag, "_empty"},      32'(empty),  32'(fill < ru));
        check({tag, "_wr_count"},   32'(wc),     32'(ewc));
        check({tag, "_rd_count"},   32'(rc),     32'(erc));
        check({tag, "_prog_full"},  32'(pfull),  32'(ewc >= pft));
        check({tag, "_prog_empty"}, 32'(pempty), 32'(erc <= pet));
        check({tag, "_overflow"},   32'(ovf),    32'(e_ovf));
        check({tag, "_underflow"},  32'(udf),    32'(e_udf));
    endtask

    // One clock of stimulus on instance A, entered and left at a falling edge.
    task automatic a_step(input bit we, input logic [7:0] d, input bit re);
        bit wa, ra;
        check_flags("a", a_fill, 1, 4, A_PF, A_PE, a_ovf_exp, a_udf_exp, a_full, a_prog_full,
                    a_overflow, a_wr_count, a_empty, a_prog_empty, a_underflow, a_rd_count);
        wa = we && !((CAP - a_fill) < 1);
        ra = re && !(a_fill < 4);
        a_din = d; a_wr_en = we; a_rd_en = re;
        a_rd_acc  = ra;
        a_ovf_exp = we && !wa;
        a_udf_exp = re && !ra;
        if (ra) a_fill -= 4;
        if (wa) begin
            a_fill += 1;
            a_acc[8*a_nb +: 8] = d;
            a_nb++;
            if (a_nb == 4) begin
                a_exp_q.push_back(a_acc);
                a_acc = '0;
                a_nb  = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic b_step(input bit we, input logic [31:0] d, input bit re);
        bit wa, ra;
        check_flags("b", b_fill, 4, 1, B_PF, B_PE, b_ovf_exp, b_udf_exp, b_full, b_prog_full,
                    b_overflow, b_wr_count, b_empty, b_prog_empty, b_underflow, b_rd_count);
        wa = we && !((CAP - b_fill) < 4);
        ra = re && !(b_fill < 1);
        b_din = d; b_wr_en = we; b_rd_en = re;
        b_rd_acc  = ra;
        b_ovf_exp = we && !wa;
        b_udf_exp = re && !ra;
        if (ra) b_fill -= 1;
        if (wa) begin
            b_fill += 4;
            b_wr_words++;
            for (int k = 0; k < 4; k++) b_exp_q.push_back(d[8*k +: 8]);
        end
        @(negedge clk);
    endtask

    // Monitor A: pops on each model-accepted read; fall-through head must always be visible.
    always begin
        @(posedge clk);
        #1;
        if (!rst_a) begin
            if (a_rd_acc) begin
                if (a_exp_q.size() == 0) sb_fail("a_sb_pop");
                else a_last = a_exp_q.pop_front();
            end
            if (a_exp_q.size() != 0) check("a_dout_head", a_dout, a_exp_q[0]);
            else                     check("a_dout_hold", a_dout, a_last);
        end
    end

    // Monitor B: standard mode, data appears the cycle after the accepted read, then holds.
    always begin
        @(posedge clk);
        #1;
        if (!rst_b) begin
            if (b_rd_acc) begin
                if (b_exp_q.size() == 0) sb_fail("b_sb_pop");
                else b_last = b_exp_q.pop_front();
            end
            check("b_dout", 32'(b_dout), 32'(b_last));
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        rst_a = 1'b1; rst_b = 1'b1;
        a_din = '0; a_wr_en = 1'b0; a_rd_en = 1'b0;
        b_din = '0; b_wr_en = 1'b0; b_rd_en = 1'b0;
        a_fill = 0; b_fill = 0; a_nb = 0; a_acc = '0; b_wr_words = 0;
        a_ovf_exp = 1'b0; a_udf_exp = 1'b0; b_ovf_exp = 1'b0; b_udf_exp = 1'b0;
        a_rd_acc = 1'b0; b_rd_acc = 1'b0; a_last = '0; b_last = '0;

        repeat (3) @(negedge clk);
        check("rst_a_full",       32'(a_full), 1);
        check("rst_a_empty",      32'(a_empty), 1);
        check("rst_a_prog_full",  32'(a_prog_full), 1);
        check("rst_a_prog_empty", 32'(a_prog_empty), 1);
        check("rst_a_dout",       a_dout, 32'h0);
        check("rst_a_wr_count",   32'(a_wr_count), 0);
        check("rst_b_full",       32'(b_full), 1);
        check("rst_b_empty",      32'(b_empty), 1);
        check("rst_b_dout",       32'(b_dout), 0);

        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("rel_a_full",       32'(a_full), 0);
        check("rel_a_prog_full",  32'(a_prog_full), 0);
        check("rel_a_empty",      32'(a_empty), 1);
        check("rel_a_prog_empty", 32'(a_prog_empty), 1);
        check("rel_a_rd_count",   32'(a_rd_count), 0);
        check("rel_b_full",       32'(b_full), 0);
        @(negedge clk);

        // Packing: first byte lands in the low lane.
        a_step(1'b1, 8'h11, 1'b0);
        a_step(1'b1, 8'h22, 1'b0);
        a_step(1'b1, 8'h33, 1'b0);
        check("pack_empty3",  32'(a_empty), 1);
        check("pack_rdcnt3",  32'(a_rd_count), 0);
        a_step(1'b1, 8'h44, 1'b0);
        check("pack_empty4",  32'(a_empty), 0);
        check("pack_rdcnt4",  32'(a_rd_count), 1);
        check("pack_wrcnt4",  32'(a_wr_count), 4);
        check("pack_dout",    a_dout, 32'h44332211);

        // Fill to full, then overflow and simultaneous read/write at full.
        for (int i = 0; i < 12; i++) a_step(1'b1, 8'($urandom), 1'b0);
        check("fill_full",    32'(a_full), 1);
        check("fill_wrcnt",   32'(a_wr_count), 16);
        a_step(1'b1, 8'hEE, 1'b0);
        check("ovf_pulse",    32'(a_overflow), 1);
        check("ovf_wrcnt",    32'(a_wr_count), 16);
        a_step(1'b1, 8'hEF, 1'b1);
        check("sim_ovf",      32'(a_overflow), 1);
        check("sim_full",     32'(a_full), 0);
        check("sim_wrcnt",    32'(a_wr_count), 12);
        check("sim_rdcnt",    32'(a_rd_count), 3);
        a_step(1'b0, 8'h00, 1'b0);
        check("ovf_drop",     32'(a_overflow), 0);

        // Drain, then underflow with dout holding the last popped word.
        repeat (3) a_step(1'b0, 8'h00, 1'b1);
        check("drain_empty",  32'(a_empty), 1);
        a_step(1'b0, 8'h00, 1'b1);
        check("udf_pulse",    32'(a_underflow), 1);
        check("udf_rdcnt",    32'(a_rd_count), 0);
        check("udf_hold",     a_dout, a_last);
        a_step(1'b0, 8'h00, 1'b1);
        check("udf_b2b",      32'(a_underflow), 1);
        a_step(1'b0, 8'h00, 1'b0);
        check("udf_drop",     32'(a_underflow), 0);

        for (int i = 0; i < 400; i++)
            a_step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 20);
        repeat (6) a_step(1'b0, 8'h00, 1'b1);
        a_step(1'b0, 8'h00, 1'b0);
        check("a_sb_left", 32'(a_exp_q.size()), 0);

        // Instance B: wide write, narrow read, standard mode, many pointer wraps.
        cyc = 0;
        while (b_wr_words < 64 && cyc < 3000) begin
            b_step($urandom_range(0, 99) < 50, $urandom, $urandom_range(0, 99) < 70);
            cyc++;
        end
        if (b_wr_words < 64) sb_fail("b_stream_budget");
        repeat (20) b_step(1'b0, 32'h0, 1'b1);
        b_step(1'b0, 32'h0, 1'b0);
        check("b_sb_left", 32'(b_exp_q.size()), 0);
        check("b_drained_empty", 32'(b_empty), 1);

        // Reset mid-operation discards stored data.
        b_step(1'b1, 32'hDEADBEEF, 1'b0);
        b_step(1'b1, 32'h01234567, 1'b1);
        rst_b = 1'b1;
        b_din = '0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_rd_acc = 1'b0;
        b_fill = 0; b_exp_q.delete(); b_last = '0; b_ovf_exp = 1'b0; b_udf_exp = 1'b0;
        #1;
        check("mid_rst_dout",  32'(b_dout), 0);
        check("mid_rst_full",  32'(b_full), 1);
        check("mid_rst_empty", 32'(b_empty), 1);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        check("mid_rel_full",  32'(b_full), 0);
        check("mid_rel_wrcnt", 32'(b_wr_count), 0);
        check("mid_rel_rdcnt", 32'(b_rd_count), 0);
        @(negedge clk);
        b_step(1'b1, 32'hA1B2C3D4, 1'b0);
        b_step(1'b0, 32'h0, 1'b1);
        check("post_rst_first", 32'(b_dout), 32'hD4);
        repeat (5) b_step(1'b0, 32'h0, 1'b1);
        b_step(1'b0, 32'h0, 1'b0);
        check("post_rst_last", 32'(b_dout), 32'hA1);
        check("b_sb_left2", 32'(b_exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
